// File: rtl/sat_acc_pkg.sv
// sat_acc_pkg: shared types and constants for the saturating multi-lane accumulator.
//   state_e        : ACCUM (no result pending) / HOLD (result register full)
//   MODE_WRAP/SAT  : values of the mode input
//   sat_max/sat_min: largest / smallest signed value at a given width, returned
//                    as a zero-extended 64-bit bit pattern (truncate to use)
package sat_acc_pkg;

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_e;

   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

   function automatic logic [63:0] sat_max(input int unsigned w);
      return (64'd1 << (w - 1)) - 64'd1;
   endfunction

   // Only the sign bit set; truncated to w bits this is the most negative value.
   function automatic logic [63:0] sat_min(input int unsigned w);
      return 64'd1 << (w - 1);
   endfunction

endpackage

// File: rtl/sat_add_lane.sv
// sat_add_lane: combinational signed two's-complement adder for one lane with
// optional saturation.
//   a, b : signed operands (WIDTH bits)
//   mode : 0 = wrap (truncated sum), 1 = clamp to max/min on overflow
//   sum  : result
//   ovf  : signed overflow occurred, independent of mode
module sat_add_lane
   import sat_acc_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mode,
   output logic [WIDTH-1:0] sum,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] MaxVal = WIDTH'(sat_max(WIDTH));
   localparam logic [WIDTH-1:0] MinVal = WIDTH'(sat_min(WIDTH));

   logic [WIDTH-1:0] raw;

   always_comb begin
      raw = a + b;
      // Same-sign operands whose truncated sum flips sign.
      ovf = (a[WIDTH-1] == b[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);
      sum = raw;
      if (ovf && (mode == MODE_SAT)) begin
         // Sign of the operands tells the overflow direction.
         sum = a[WIDTH-1] ? MinVal : MaxVal;
      end
   end

endmodule

// File: rtl/sat_accumulator.sv
// sat_accumulator: multi-lane signed accumulator summing packets of beats
// (delimited by in_last) per lane, with wrap/saturate mode, sticky per-lane
// overflow flags and a saturating beat counter.
//   clk, rst            : clock (rising edge), async active-high reset
//   clr                 : synchronous clear of the in-progress accumulation
//   mode                : 0 = wrap, 1 = saturate; sampled per accepted beat
//   in_valid/in_ready   : input beat handshake; in_data packed lanes, in_last
//   out_valid/out_ready : result handshake
//   out_data/ovf/cnt    : per-lane sums, sticky overflow flags, beat count
module sat_accumulator
   import sat_acc_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned LANES = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clr,
   input  logic                   mode,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [LANES*WIDTH-1:0] in_data,
   input  logic                   in_last,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LANES*WIDTH-1:0] out_data,
   output logic [LANES-1:0]       out_ovf,
   output logic [CNT_W-1:0]       out_cnt
);

   state_e                 state_q, state_d;
   logic [LANES*WIDTH-1:0] acc_q, acc_d;
   logic [LANES-1:0]       ovf_q, ovf_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [LANES*WIDTH-1:0] out_data_q, out_data_d;
   logic [LANES-1:0]       out_ovf_q, out_ovf_d;
   logic [CNT_W-1:0]       out_cnt_q, out_cnt_d;

   logic [LANES*WIDTH-1:0] lane_sum;
   logic [LANES-1:0]       lane_ovf;
   logic [CNT_W-1:0]       cnt_inc;
   logic                   accept;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      sat_add_lane #(
         .WIDTH(WIDTH)
      ) u_lane (
         .a   (acc_q[g*WIDTH +: WIDTH]),
         .b   (in_data[g*WIDTH +: WIDTH]),
         .mode(mode),
         .sum (lane_sum[g*WIDTH +: WIDTH]),
         .ovf (lane_ovf[g])
      );
   end

   // A full result register can still take a beat if the consumer drains it now.
   assign in_ready  = ~clr & ((state_q == ACCUM) | out_ready);
   assign accept    = in_valid & in_ready;
   assign cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
   assign out_valid = (state_q == HOLD);
   assign out_data  = out_data_q;
   assign out_ovf   = out_ovf_q;
   assign out_cnt   = out_cnt_q;

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      ovf_d      = ovf_q;
      cnt_d      = cnt_q;
      out_data_d = out_data_q;
      out_ovf_d  = out_ovf_q;
      out_cnt_d  = out_cnt_q;

      // Consumer drains the result; overridden below if a new result lands.
      if ((state_q == HOLD) && out_ready) begin
         state_d = ACCUM;
      end

      if (clr) begin
         acc_d = '0;
         ovf_d = '0;
         cnt_d = '0;
      end else if (accept) begin
         if (in_last) begin
            out_data_d = lane_sum;
            out_ovf_d  = ovf_q | lane_ovf;
            out_cnt_d  = cnt_inc;
            state_d    = HOLD;
            acc_d      = '0;
            ovf_d      = '0;
            cnt_d      = '0;
         end else begin
            acc_d = lane_sum;
            ovf_d = ovf_q | lane_ovf;
            cnt_d = cnt_inc;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ACCUM;
         acc_q      <= '0;
         ovf_q      <= '0;
         cnt_q      <= '0;
         out_data_q <= '0;
         out_ovf_q  <= '0;
         out_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         ovf_q      <= ovf_d;
         cnt_q      <= cnt_d;
         out_data_q <= out_data_d;
         out_ovf_q  <= out_ovf_d;
         out_cnt_q  <= out_cnt_d;
      end
   end

endmodule
